mips_mmio_responder: RTL and testbench

// Memory-mapped I/O responder on the MIPS processor's data-memory bus. The core initiates loads and stores;

---
 rtl/mips_mmio_responder.sv | 128 ++++++++++++
 tb/tb_mips_mmio_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mmio_responder.sv
// Memory-mapped I/O responder on the MIPS data bus: output port, synchronised
// input port with change detect, interval timer and an interrupt line.
module mips_mmio_responder #(
  parameter logic [31:0] IO_BASE  = 32'hFFFF_0000,
  parameter int          IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic [31:0]         PortOut,
  output logic                IOSelect,
  output logic                Irq
);

  localparam logic [2:0] REG_PORT_OUT = 3'd0;
  localparam logic [2:0] REG_PORT_IN  = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_TMR_CMP  = 3'd3;
  localparam logic [2:0] REG_TMR_CNT  = 3'd4;
  localparam logic [2:0] REG_CTRL     = 3'd5;

  logic [31:0]         portOutReg, portOutNext;
  logic [31:0]         cmpReg, cmpNext;
  logic [31:0]         cntReg, cntNext;
  logic [31:0]         ctrlReg, ctrlNext;
  logic                inChgReg, inChgNext;
  logic                tmrExpReg, tmrExpNext;
  logic                irqReg, irqNext;
  logic [IN_WIDTH-1:0] sync1Reg, sync2Reg, prevReg;

  logic [2:0]  wordSel;
  logic        wrEn;
  logic        statusRd;
  logic        wrap;
  logic [31:0] portInExt;
  logic [1:0]  unusedAddr;

  assign wordSel    = Address[4:2];
  assign unusedAddr = Address[1:0];
  assign IOSelect   = (Address[31:5] == IO_BASE[31:5]);
  assign wrEn       = MemWrite & IOSelect;
  assign statusRd   = MemRead & IOSelect & (wordSel == REG_STATUS);
  assign portInExt  = 32'(sync2Reg);
  assign PortOut    = portOutReg;
  assign Irq        = irqReg;

  always_comb begin
    portOutNext = portOutReg;
    cmpNext     = cmpReg;
    ctrlNext    = ctrlReg;
    wrap        = (cmpReg != 32'd0) && (cntReg == cmpReg);

    // Set events win over the read-to-clear of STATUS on the same edge.
    inChgNext = inChgReg;
    if (statusRd) inChgNext = 1'b0;
    if (sync2Reg != prevReg) inChgNext = 1'b1;

    tmrExpNext = tmrExpReg;
    if (statusRd) tmrExpNext = 1'b0;
    if (wrap) tmrExpNext = 1'b1;

    if (cmpReg == 32'd0 || wrap) cntNext = 32'd0;
    else cntNext = cntReg + 32'd1;

    if (wrEn) begin
      case (wordSel)
        REG_PORT_OUT: portOutNext = WriteData;
        REG_TMR_CMP: begin
          // Reprogramming restarts the period and overrides a coincident wrap.
          cmpNext    = WriteData;
          cntNext    = 32'd0;
          tmrExpNext = 1'b0;
        end
        REG_CTRL: ctrlNext = WriteData;
        default: ;
      endcase
    end

    irqNext = tmrExpNext & ctrlNext[0];
  end

  always_comb begin
    ReadData = 32'd0;
    if (IOSelect) begin
      case (wordSel)
        REG_PORT_OUT: ReadData = portOutReg;
        REG_PORT_IN:  ReadData = portInExt;
        REG_STATUS:   ReadData = {30'd0, tmrExpReg, inChgReg};
        REG_TMR_CMP:  ReadData = cmpReg;
        REG_TMR_CNT:  ReadData = cntReg;
        REG_CTRL:     ReadData = ctrlReg;
        default:      ReadData = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      portOutReg <= '0;
      cmpReg     <= '0;
      cntReg     <= '0;
      ctrlReg    <= '0;
      inChgReg   <= 1'b0;
      tmrExpReg  <= 1'b0;
      irqReg     <= 1'b0;
      sync1Reg   <= '0;
      sync2Reg   <= '0;
      prevReg    <= '0;
    end else begin
      portOutReg <= portOutNext;
      cmpReg     <= cmpNext;
      cntReg     <= cntNext;
      ctrlReg    <= ctrlNext;
      inChgReg   <= inChgNext;
      tmrExpReg  <= tmrExpNext;
      irqReg     <= irqNext;
      sync1Reg   <= PortIn;
      sync2Reg   <= sync1Reg;
      prevReg    <= sync2Reg;
    end
  end

endmodule

// File: tb/tb_mips_mmio_responder.sv
// Bench for mips_mmio_responder: directed scenarios plus randomized bus traffic
// checked against a cycle-level behavioural model of the register map.
module tb_mips_mmio_responder;

  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [7:0]  PortIn = 8'd0;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
  logic        IOSelect;
  logic        Irq;

  int nPass = 0;
  int nChecks = 0;

  mips_mmio_responder #(.IO_BASE(IO_BASE), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
    .ReadData(ReadData), .PortOut(PortOut), .IOSelect(IOSelect), .Irq(Irq)
  );

  always #10 clk = ~clk;

  // Behavioural model: timer expressed as cycles elapsed since programming.
  logic [31:0]     mPortOut, mCmp, mCtrl;
  longint unsigned mElapsed;
  bit              mInChg, mTmrExp, mIrq;
  logic [7:0]      mSamp [3];

  function automatic logic [31:0] mCnt();
    if (mCmp == 32'd0) return 32'd0;
    return 32'(mElapsed % (64'(mCmp) + 64'd1));
  endfunction

  function automatic bit mSel(input logic [31:0] a);
    return (a[31:5] == IO_BASE[31:5]);
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    if (!mSel(a)) return 32'd0;
    case (a[4:2])
      3'd0: return mPortOut;
      3'd1: return {24'd0, mSamp[1]};
      3'd2: return {30'd0, mTmrExp, mInChg};
      3'd3: return mCmp;
      3'd4: return mCnt();
      3'd5: return mCtrl;
      default: return 32'd0;
    endcase
  endfunction

  task automatic mStep();
    bit wr, sRd, wrapNow, chg, nIn, nExp;
    if (reset) begin
      mPortOut = 0; mCmp = 0; mCtrl = 0; mElapsed = 0;
      mInChg = 0; mTmrExp = 0; mIrq = 0;
      for (int i = 0; i < 3; i++) mSamp[i] = 8'd0;
      return;
    end
    wr      = MemWrite && mSel(Address);
    sRd     = MemRead && mSel(Address) && Address[4:2] == 3'd2;
    wrapNow = (mCmp != 0) && (mCnt() == mCmp);
    chg     = (mSamp[1] != mSamp[2]);
    nIn     = chg ? 1'b1 : (sRd ? 1'b0 : mInChg);
    nExp    = wrapNow ? 1'b1 : (sRd ? 1'b0 : mTmrExp);
    mElapsed++;
    if (wr && Address[4:2] == 3'd0) mPortOut = WriteData;
    if (wr && Address[4:2] == 3'd5) mCtrl = WriteData;
    if (wr && Address[4:2] == 3'd3) begin
      mCmp = WriteData; mElapsed = 0; nExp = 1'b0;
    end
    mInChg = nIn; mTmrExp = nExp;
    mIrq = nExp & mCtrl[0];
    mSamp[2] = mSamp[1]; mSamp[1] = mSamp[0]; mSamp[0] = PortIn;
  endtask

  task automatic setBus(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd);
    MemWrite = we; MemRead = re; Address = a; WriteData = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    mStep();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setBus(0, 0, IO_BASE, 0);
    tick(); tick();
    reset = 1'b0;
    nChecks++; if (PortOut !== 32'd0) $display("FAIL reset_portout got %h want 0", PortOut); else nPass++;
    nChecks++; if (Irq !== 1'b0) $display("FAIL reset_irq got %b want 0", Irq); else nPass++;
    for (int i = 0; i < 8; i++) begin
      setBus(0, 0, IO_BASE + 32'(i * 4), 0);
      nChecks++;
      if (ReadData !== 32'd0) $display("FAIL reset_read off=%0h got %h want 0", i * 4, ReadData); else nPass++;
    end
  endtask

  task automatic test_portout();
    setBus(1, 0, IO_BASE, 32'h0000_00A5);
    tick();
    setBus(0, 1, IO_BASE, 0);
    nChecks++; if (PortOut !== 32'hA5) $display("FAIL portout got %h want a5", PortOut); else nPass++;
    nChecks++; if (ReadData !== 32'hA5) $display("FAIL portout_read got %h want a5", ReadData); else nPass++;
    nChecks++; if (IOSelect !== 1'b1) $display("FAIL portout_iosel got %b want 1", IOSelect); else nPass++;
    tick();
  endtask

  task automatic test_portin();
    setBus(0, 0, IO_BASE + 32'h4, 0);
    PortIn = 8'h3C;
    tick();
    nChecks++; if (ReadData !== 32'd0) $display("FAIL portin_k got %h want 0", ReadData); else nPass++;
    tick();
    nChecks++; if (ReadData !== 32'h3C) $display("FAIL portin_k1 got %h want 3c", ReadData); else nPass++;
    setBus(0, 0, IO_BASE + 32'h8, 0);
    nChecks++; if (ReadData !== 32'd0) $display("FAIL status_k1 got %h want 0", ReadData); else nPass++;
    tick();
    nChecks++; if (ReadData !== 32'h1) $display("FAIL status_k2 got %h want 1", ReadData); else nPass++;
    setBus(0, 1, IO_BASE + 32'h8, 0);
    tick();
    setBus(0, 0, IO_BASE + 32'h8, 0);
    nChecks++; if (ReadData !== 32'd0) $display("FAIL status_clear got %h want 0", ReadData); else nPass++;
  endtask

  task automatic test_timer();
    setBus(1, 0, IO_BASE + 32'h14, 32'd1);
    tick();
    setBus(1, 0, IO_BASE + 32'hC, 32'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      setBus(0, 0, IO_BASE + 32'h10, 0);
      nChecks++;
      if (ReadData !== 32'(i % 4)) $display("FAIL tmr_cnt cyc=%0d got %h want %h", i, ReadData, i % 4); else nPass++;
      setBus(0, 0, IO_BASE + 32'h8, 0);
      nChecks++;
      if (ReadData[1] !== (i >= 4)) $display("FAIL tmr_exp cyc=%0d got %b want %b", i, ReadData[1], i >= 4); else nPass++;
      nChecks++;
      if (Irq !== mIrq) $display("FAIL tmr_irq cyc=%0d got %b want %b", i, Irq, mIrq); else nPass++;
      tick();
    end
  endtask

  task automatic test_collisions();
    int n;
    PortIn = 8'h5A;
    setBus(0, 0, IO_BASE, 0);
    tick(); tick();
    setBus(0, 1, IO_BASE + 32'h8, 0);
    tick();
    setBus(0, 0, IO_BASE + 32'h8, 0);
    nChecks++; if (ReadData[0] !== 1'b1) $display("FAIL chg_set_wins got %h want bit0=1", ReadData); else nPass++;
    nChecks++; if (ReadData !== mRead(Address)) $display("FAIL chg_status got %h want %h", ReadData, mRead(Address)); else nPass++;
    n = 0;
    while (!(mCmp != 0 && mCnt() == mCmp) && n < 10) begin tick(); n++; end
    nChecks++; if (n >= 10) $display("FAIL wrap_wait got timeout want wrap edge"); else nPass++;
    setBus(1, 0, IO_BASE + 32'hC, 32'd3);
    tick();
    setBus(0, 0, IO_BASE + 32'h10, 0);
    nChecks++; if (ReadData !== 32'd0) $display("FAIL cmp_wr_cnt got %h want 0", ReadData); else nPass++;
    setBus(0, 0, IO_BASE + 32'h8, 0);
    nChecks++; if (ReadData[1] !== 1'b0) $display("FAIL cmp_wr_exp got %b want 0", ReadData[1]); else nPass++;
  endtask

  task automatic test_reset_midcount();
    int n;
    setBus(1, 0, IO_BASE, 32'hA5);
    tick();
    PortIn = 8'hC3;
    setBus(1, 0, IO_BASE + 32'hC, 32'd3);
    tick();
    setBus(0, 0, IO_BASE + 32'h8, 0);
    n = 0;
    while (!(mCnt() == 2 && mTmrExp && mInChg) && n < 20) begin tick(); n++; end
    nChecks++; if (ReadData !== 32'h3) $display("FAIL pre_reset_status got %h want 3", ReadData); else nPass++;
    reset = 1'b1;
    setBus(1, 0, IO_BASE, 32'h0000_FFFF);
    tick();
    reset = 1'b0;
    setBus(0, 0, IO_BASE, 0);
    nChecks++; if (PortOut !== 32'd0) $display("FAIL midreset_portout got %h want 0", PortOut); else nPass++;
    nChecks++; if (Irq !== 1'b0) $display("FAIL midreset_irq got %b want 0", Irq); else nPass++;
    for (int i = 0; i < 6; i++) begin
      setBus(0, 0, IO_BASE + 32'(i * 4), 0);
      nChecks++;
      if (ReadData !== 32'd0) $display("FAIL midreset_read off=%0h got %h want 0", i * 4, ReadData); else nPass++;
    end
    tick();
    setBus(0, 0, IO_BASE + 32'h10, 0);
    nChecks++; if (ReadData !== 32'd0) $display("FAIL midreset_idle_cnt got %h want 0", ReadData); else nPass++;
  endtask

  task automatic test_window();
    setBus(0, 1, 32'h1001_0000, 0);
    nChecks++; if (IOSelect !== 1'b0) $display("FAIL out_iosel got %b want 0", IOSelect); else nPass++;
    nChecks++; if (ReadData !== 32'd0) $display("FAIL out_read got %h want 0", ReadData); else nPass++;
    setBus(1, 0, IO_BASE + 32'h4, 32'hDEAD_BEEF);
    tick();
    setBus(1, 0, IO_BASE + 32'h18, 32'h1234_5678);
    tick();
    setBus(1, 0, 32'h1001_0000, 32'h0BAD_F00D);
    tick();
    setBus(0, 0, IO_BASE, 0);
    nChecks++; if (PortOut !== 32'd0) $display("FAIL ignored_wr_portout got %h want 0", PortOut); else nPass++;
    for (int i = 0; i < 8; i++) begin
      setBus(0, 0, IO_BASE + 32'(i * 4), 0);
      nChecks++;
      if (ReadData !== mRead(Address)) $display("FAIL ignored_wr_read off=%0h got %h want %h", i * 4, ReadData, mRead(Address)); else nPass++;
    end
    setBus(0, 1, IO_BASE + 32'h1C, 0);
    nChecks++; if (ReadData !== 32'd0) $display("FAIL read_1c got %h want 0", ReadData); else nPass++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) == 0) PortIn = 8'($urandom);
      a = ($urandom_range(0, 9) < 8) ? (IO_BASE | 32'($urandom_range(0, 31))) : $urandom;
      wd = (a[4:2] == 3'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      setBus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      nChecks++;
      if (ReadData !== mRead(a) || IOSelect !== mSel(a))
        $display("FAIL rnd_read cyc=%0d addr=%h got %h/%b want %h/%b", i, a, ReadData, IOSelect, mRead(a), mSel(a));
      else nPass++;
      nChecks++;
      if (PortOut !== mPortOut || Irq !== mIrq)
        $display("FAIL rnd_state cyc=%0d got %h/%b want %h/%b", i, PortOut, Irq, mPortOut, mIrq);
      else nPass++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_portout();
    test_portin();
    test_timer();
    test_collisions();
    test_reset_midcount();
    test_window();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
